// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - fixed-latency word-addressed RAM target for the core memory port
//
// Purpose: accepts one read or write request while idle, waits LATENCY cycles, then
// completes it with a one-cycle memory_valid pulse. Out-of-range accesses complete
// with access_fault set, read data 0 and no RAM change.
//
// Ports:
//   clk                  - clock, all state on rising edge
//   reset                - asynchronous active-low reset
//   memory_enable        - request strobe, taken when memory_ready is high
//   memory_command       - 0 = read, 1 = write
//   read_memory_address  - byte address used for reads
//   write_memory_address - byte address used for writes
//   write_memory_data    - write data
//   write_memory_mask    - per-bit write enable
//   memory_ready         - high only while idle
//   memory_valid         - one-cycle completion pulse
//   read_memory_data     - registered read result, held until the next read response
//   access_fault         - qualifies memory_valid: address outside the RAM window

module memory_responder #(
    parameter int          DEPTH_WORDS  = 4096,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          LATENCY      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_enable,
    input  logic        memory_command,
    input  logic [31:0] read_memory_address,
    input  logic [31:0] write_memory_address,
    input  logic [31:0] write_memory_data,
    input  logic [31:0] write_memory_mask,
    output logic        memory_ready,
    output logic        memory_valid,
    output logic [31:0] read_memory_data,
    output logic        access_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          cmd_q, cmd_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          hit_q, hit_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   wmask_q, wmask_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [29:0]   sel_word;
    logic [29:0]   word_off;
    logic          borrow;
    logic          sel_hit;
    logic          commit;

    // Byte-lane bits are ignored; the core deals with misalignment.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{read_memory_address[1:0], write_memory_address[1:0]};

    // Word offset from the base; the borrow out flags addresses below BASE_ADDRESS.
    always_comb begin
        sel_word = memory_command ? write_memory_address[31:2] : read_memory_address[31:2];
        {borrow, word_off} = {1'b0, sel_word} - {1'b0, BASE_ADDRESS[31:2]};
        sel_hit = !borrow && ({2'b00, word_off} < 32'(DEPTH_WORDS));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (memory_enable && ready_q) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                    cmd_d   = memory_command;
                    idx_d   = word_off[AW-1:0];
                    hit_d   = sel_hit;
                    wdata_d = write_memory_data;
                    wmask_d = write_memory_mask;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    // Only read responses update the data register.
                    if (!cmd_q) begin
                        rdata_d = hit_q ? mem[idx_q] : 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_RESP);
        fault_d = (state_d == S_RESP) && !hit_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= 1'b0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            wdata_q <= 32'h0;
            wmask_q <= 32'h0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Write commits on the edge entering RESP; reset held low blocks an in-flight write.
    assign commit = reset && (state_q == S_WAIT) && (cnt_q == 4'd0) && cmd_q && hit_q;

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx_q] <= (mem[idx_q] & ~wmask_q) | (wdata_q & wmask_q);
        end
    end

    assign memory_ready     = ready_q;
    assign memory_valid     = valid_q;
    assign read_memory_data = rdata_q;
    assign access_fault     = fault_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - scoreboard bench for memory_responder (LATENCY 2 and 1 instances)

module tb_memory_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        en2, en1;
    logic        cmd;
    logic [31:0] raddr, waddr, wdata, wmask;
    logic        r2, v2, f2, r1, v1, f1;
    logic [31:0] d2, d1;

    always #5 clk = ~clk;

    memory_responder #(.DEPTH_WORDS(4096), .BASE_ADDRESS(32'h0), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .memory_enable(en2), .memory_command(cmd),
        .read_memory_address(raddr), .write_memory_address(waddr),
        .write_memory_data(wdata), .write_memory_mask(wmask),
        .memory_ready(r2), .memory_valid(v2), .read_memory_data(d2), .access_fault(f2));

    memory_responder #(.DEPTH_WORDS(4096), .BASE_ADDRESS(32'h0), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .memory_enable(en1), .memory_command(cmd),
        .read_memory_address(raddr), .write_memory_address(waddr),
        .write_memory_data(wdata), .write_memory_mask(wmask),
        .memory_ready(r1), .memory_valid(v1), .read_memory_data(d1), .access_fault(f1));

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          due;
    } exp_t;

    exp_t        q2[$];
    exp_t        q1[$];
    logic [31:0] sh2 [int];
    logic [31:0] sh1 [int];
    logic [31:0] last2, last1;
    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;
    int          vcount1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'h0000_4000;
    endfunction

    // Scoreboard: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon2
        exp_t e;
        if (reset === 1'b1) begin
            if (v2 === 1'b1) begin
                checks++;
                if (q2.size() == 0) begin
                    $display("FAIL dut2_unexpected_valid at cycle %0d data=%h", cyc, d2);
                end else begin
                    e = q2.pop_front();
                    if (d2 !== e.data || f2 !== e.fault || cyc !== e.due)
                        $display("FAIL dut2_response got data=%h fault=%b cycle=%0d want data=%h fault=%b cycle=%0d",
                                 d2, f2, cyc, e.data, e.fault, e.due);
                    else passed++;
                end
            end else begin
                checks++;
                if (f2 !== 1'b0) $display("FAIL dut2_fault_without_valid got %b want 0", f2);
                else passed++;
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (reset === 1'b1 && v1 === 1'b1) begin
            vcount1++;
            checks++;
            if (q1.size() == 0) begin
                $display("FAIL dut1_unexpected_valid at cycle %0d data=%h", cyc, d1);
            end else begin
                e = q1.pop_front();
                if (d1 !== e.data || f1 !== e.fault || cyc !== e.due)
                    $display("FAIL dut1_response got data=%h fault=%b cycle=%0d want data=%h fault=%b cycle=%0d",
                             d1, f1, cyc, e.data, e.fault, e.due);
                else passed++;
            end
        end
    end

    // Called at a negedge. Holds the request until accepted, then builds the expectation.
    task automatic access(input int which, input logic c, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] m,
                          input bit expect_resp, output int acc);
        exp_t        e;
        int          tries;
        int          idx;
        logic [31:0] old;
        cmd   = c;
        raddr = c ? ~a : a;
        waddr = c ? a : ~a;
        wdata = d;
        wmask = m;
        if (which == 2) en2 = 1'b1; else en1 = 1'b1;
        tries = 0;
        while (((which == 2) ? r2 : r1) !== 1'b1 && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        acc = -1;
        if (tries >= 50) begin
            checks++;
            $display("FAIL accept_timeout dut%0d ready never rose within 50 cycles", which);
        end else begin
            acc = cyc + 1;
            idx = int'(a >> 2);
            e.fault = !in_range(a);
            e.due   = acc + ((which == 2) ? 2 : 1);
            if (!c) begin
                if (!in_range(a)) e.data = 32'h0;
                else e.data = (which == 2) ? sh2[idx] : sh1[idx];
                if (expect_resp) begin
                    if (which == 2) last2 = e.data; else last1 = e.data;
                end
            end else begin
                e.data = (which == 2) ? last2 : last1;
                if (expect_resp && in_range(a)) begin
                    if (which == 2) old = sh2.exists(idx) ? sh2[idx] : 32'h0;
                    else            old = sh1.exists(idx) ? sh1[idx] : 32'h0;
                    if (which == 2) sh2[idx] = (old & ~m) | (d & m);
                    else            sh1[idx] = (old & ~m) | (d & m);
                end
            end
            if (expect_resp) begin
                if (which == 2) q2.push_back(e); else q1.push_back(e);
            end
        end
        @(negedge clk);
        en2 = 1'b0;
        en1 = 1'b0;
        // Scramble the bus to show only accept-time values matter.
        cmd   = ~c;
        raddr = $urandom;
        waddr = $urandom;
        wdata = $urandom;
        wmask = $urandom;
    endtask

    task automatic drain(input int which);
        int n = 0;
        while (((which == 2) ? q2.size() : q1.size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (((which == 2) ? q2.size() : q1.size()) != 0) begin
            checks++;
            $display("FAIL drain_timeout dut%0d responses outstanding=%0d want 0", which,
                     (which == 2) ? q2.size() : q1.size());
        end
        n = 0;
        while (((which == 2) ? r2 : r1) !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (r2 !== 1'b1) $display("FAIL reset_ready got %b want 1", r2); else passed++;
        if (v2 !== 1'b0) $display("FAIL reset_valid got %b want 0", v2); else passed++;
        if (d2 !== 32'h0) $display("FAIL reset_rdata got %h want 0", d2); else passed++;
        if (f2 !== 1'b0) $display("FAIL reset_fault got %b want 0", f2); else passed++;
        reset = 1'b1;
        @(negedge clk);
        checks += 3;
        if (r2 !== 1'b1) $display("FAIL post_reset_ready got %b want 1", r2); else passed++;
        if (v2 !== 1'b0) $display("FAIL post_reset_valid got %b want 0", v2); else passed++;
        if (d2 !== 32'h0) $display("FAIL post_reset_rdata got %h want 0", d2); else passed++;
    endtask

    task automatic test_write_read();
        int acc;
        int n;
        access(2, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, acc);
        n = 0;
        while (r2 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cyc !== acc + 3) $display("FAIL write_ready_return got cycle %0d want %0d", cyc, acc + 3);
        else passed++;
        access(2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, acc);
        drain(2);
    endtask

    task automatic test_partial_write();
        int acc;
        access(2, 1'b1, 32'h10, 32'h0000_00AA, 32'h0000_00FF, 1'b1, acc);
        access(2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, acc);
        access(2, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, acc);
        drain(2);
        checks++;
        if (d2 !== 32'hDEAD_BEAA) $display("FAIL partial_hold got %h want deadbeaa", d2); else passed++;
        access(2, 1'b1, 32'h10, 32'h1234_5678, 32'h0, 1'b1, acc);
        access(2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, acc);
        drain(2);
    endtask

    task automatic test_out_of_range();
        int acc;
        access(2, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'hFFFF_FFFF, 1'b1, acc);
        access(2, 1'b1, 32'h0000_3FFC, 32'h2222_2222, 32'hFFFF_FFFF, 1'b1, acc);
        access(2, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 1'b1, acc);
        access(2, 1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, acc);
        access(2, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, acc);
        access(2, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b1, acc);
        access(2, 1'b0, 32'h0000_3FFC, 32'h0, 32'h0, 1'b1, acc);
        access(2, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b1, acc);
        drain(2);
    endtask

    task automatic test_back_to_back();
        int acc;
        int start;
        exp_t e;
        for (int k = 0; k < 15; k++)
            access(1, 1'b1, 32'h40 + 32'(4 * k), 32'hA500_0000 + 32'(k), 32'hFFFF_FFFF, 1'b1, acc);
        drain(1);
        start = vcount1;
        cmd = 1'b0;
        en1 = 1'b1;
        for (int k = 0; k < 15; k++) begin
            raddr = 32'h40 + 32'(4 * k);
            waddr = 32'hFFFF_0000;
            checks++;
            if (r1 !== ((k % 3) == 0)) $display("FAIL b2b_ready step %0d got %b want %b", k, r1, (k % 3) == 0);
            else passed++;
            if ((k % 3) == 0) begin
                e.data  = sh1[(32'h40 >> 2) + k];
                e.fault = 1'b0;
                e.due   = cyc + 2;
                last1   = e.data;
                q1.push_back(e);
            end
            @(negedge clk);
        end
        en1 = 1'b0;
        drain(1);
        checks++;
        if (vcount1 - start !== 5) $display("FAIL b2b_pulse_count got %0d want 5", vcount1 - start);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int acc;
        access(2, 1'b1, 32'h20, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, acc);
        drain(2);
        access(2, 1'b1, 32'h20, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0, acc);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks += 2;
        if (v2 !== 1'b0) $display("FAIL abort_valid got %b want 0", v2); else passed++;
        if (r2 !== 1'b1) $display("FAIL abort_ready got %b want 1", r2); else passed++;
        reset = 1'b1;
        last2 = 32'h0;
        last1 = 32'h0;
        repeat (4) @(negedge clk);
        access(2, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, acc);
        drain(2);
    endtask

    initial begin
        reset = 1'b0;
        en2 = 1'b0;
        en1 = 1'b0;
        cmd = 1'b0;
        raddr = 32'h0;
        waddr = 32'h0;
        wdata = 32'h0;
        wmask = 32'h0;
        last2 = 32'h0;
        last1 = 32'h0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_partial_write();
        test_out_of_range();
        test_back_to_back();
        test_reset_abort();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
